// File: rtl/adc_spi_scheduler.sv
// adc_spi_scheduler
// Schedules ADC conversions over an external SPI engine. Periodic sample
// ticks and one-cycle on-demand requests are queued as pending flags and
// served one at a time (periodic has priority). Each served request issues
// a one-cycle spi_start and waits for the engine's result, with a bounded
// timeout. Periodic results are also averaged over 2^AVG_LOG2 samples.
//
// Ports
//   clk            : single clock
//   reset          : synchronous, active-high reset
//   en             : enables periodic tick generation
//   req_demand     : one-cycle on-demand sample request
//   spi_start      : one-cycle start pulse to the SPI engine
//   spi_data_valid : one-cycle pulse qualifying spi_data
//   spi_data       : 12-bit conversion result
//   sample_out     : last delivered sample
//   sample_valid   : one-cycle pulse when sample_out updates
//   sample_src     : 0 = periodic, 1 = demand
//   avg_out        : last completed average
//   avg_valid      : one-cycle pulse when avg_out updates
//   overrun        : sticky, a periodic tick was lost
//   timeout_err    : one-cycle pulse when a transaction is abandoned
module adc_spi_scheduler #(
  parameter int PERIOD   = 1000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req_demand,
  output logic        spi_start,
  input  logic        spi_data_valid,
  input  logic [11:0] spi_data,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  output logic        sample_src,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int DATA_W = 12;
  localparam int TCNT_W = $clog2(PERIOD);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  AVG_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic                r_per_pend;
  logic                r_dem_pend;
  logic                r_src;
  logic [TO_W-1:0]     r_to_cnt;
  logic [DATA_W-1:0]   r_spi_data;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_acc_cnt;
  logic                r_spi_start;
  logic [DATA_W-1:0]   r_sample_out;
  logic                r_sample_valid;
  logic                r_sample_src;
  logic [DATA_W-1:0]   r_avg_out;
  logic                r_avg_valid;
  logic                r_overrun;
  logic                r_timeout_err;

  logic                w_tick;
  logic                w_grant_per;
  logic                w_grant_dem;
  logic [ACC_W-1:0]    w_acc_sum;

  // Truncating divide by 2^AVG_LOG2.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    avg_trunc = DATA_W'(sum >> AVG_LOG2);
  endfunction

  assign w_tick      = en && (r_tick_cnt == TICK_LAST);
  assign w_grant_per = (r_state == S_IDLE) && r_per_pend;
  assign w_grant_dem = (r_state == S_IDLE) && !r_per_pend && r_dem_pend;
  assign w_acc_sum   = r_acc + ACC_W'(r_spi_data);

  // Tick generation and pending request flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_per_pend <= 1'b0;
      r_dem_pend <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (!en || r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
      else                                r_tick_cnt <= r_tick_cnt + TCNT_W'(1);

      // A flag being granted this cycle is free, so a coincident tick queues.
      if (w_tick) begin
        if (r_per_pend && !w_grant_per) r_overrun  <= 1'b1;
        else                            r_per_pend <= 1'b1;
      end else if (w_grant_per) begin
        r_per_pend <= 1'b0;
      end

      if (req_demand && (!r_dem_pend || w_grant_dem)) r_dem_pend <= 1'b1;
      else if (w_grant_dem)                           r_dem_pend <= 1'b0;
    end
  end

  // Transaction FSM, sample delivery and averaging
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_src          <= 1'b0;
      r_to_cnt       <= '0;
      r_acc          <= '0;
      r_acc_cnt      <= '0;
      r_spi_start    <= 1'b0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_sample_src   <= 1'b0;
      r_avg_out      <= '0;
      r_avg_valid    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_spi_start    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_avg_valid    <= 1'b0;
      r_timeout_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_per || w_grant_dem) begin
            r_src       <= w_grant_dem;
            r_spi_start <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_data_valid) begin
            r_spi_data <= spi_data;
            r_state    <= S_DONE;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          r_sample_out   <= r_spi_data;
          r_sample_src   <= r_src;
          r_sample_valid <= 1'b1;
          if (!r_src) begin
            if (r_acc_cnt == AVG_LAST) begin
              r_avg_out   <= avg_trunc(w_acc_sum);
              r_avg_valid <= 1'b1;
              r_acc       <= '0;
              r_acc_cnt   <= '0;
            end else begin
              r_acc     <= w_acc_sum;
              r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_start    = r_spi_start;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign sample_src   = r_sample_src;
  assign avg_out      = r_avg_out;
  assign avg_valid    = r_avg_valid;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc_spi_scheduler.sv
module tb_adc_spi_scheduler;

  typedef struct {
    logic [11:0] data;
    logic        src;
    bit          expect_out;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        req_demand;
  logic        spi_start;
  logic        spi_data_valid;
  logic [11:0] spi_data;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        sample_src;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        overrun;
  logic        timeout_err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_samples = 0;
  int n_avg    = 0;
  int n_starts = 0;
  int last_start = 0;
  int spi_lat  = 3;
  int pend_cnt = 0;
  bit spur     = 0;
  logic [11:0] spur_data = '0;
  int m_acc    = 0;
  int m_cnt    = 0;

  resp_t resp_q[$];
  resp_t exp_q[$];
  int    vcyc_q[$];
  logic [11:0] avg_q[$];
  resp_t cur;

  adc_spi_scheduler #(.PERIOD(16), .AVG_LOG2(2), .TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .req_demand     (req_demand),
    .spi_start      (spi_start),
    .spi_data_valid (spi_data_valid),
    .spi_data       (spi_data),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .sample_src     (sample_src),
    .avg_out        (avg_out),
    .avg_valid      (avg_valid),
    .overrun        (overrun),
    .timeout_err    (timeout_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_samples(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_samples < target; i++) @(negedge clk);
    check(tag, n_samples >= target, 1);
    step(1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) break;
    end
    check(tag, i < budget, 1);
  endtask

  // SPI engine model: answers each spi_start after spi_lat cycles with the
  // next queued response and records what the scheduler should deliver.
  initial begin
    spi_data_valid = 1'b0;
    spi_data       = '0;
    cur            = '{data: '0, src: 1'b0, expect_out: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      spi_data_valid = 1'b0;
      if (reset === 1'b1) begin
        m_acc = 0;
        m_cnt = 0;
        cur.expect_out = 1'b0;
      end
      if (spur) begin
        spi_data_valid = 1'b1;
        spi_data       = spur_data;
        spur           = 1'b0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          spi_data_valid = 1'b1;
          spi_data       = cur.data;
          if (cur.expect_out) begin
            exp_q.push_back(cur);
            vcyc_q.push_back(cyc);
            if (!cur.src) begin
              m_acc += int'(cur.data);
              m_cnt++;
              if (m_cnt == 4) begin
                avg_q.push_back(12'(m_acc >> 2));
                m_acc = 0;
                m_cnt = 0;
              end
            end
          end
        end
      end
      if (spi_start === 1'b1) begin
        n_starts++;
        last_start = cyc;
        if (resp_q.size() > 0) begin
          cur      = resp_q.pop_front();
          pend_cnt = spi_lat;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every delivered sample/average.
  always @(negedge clk) begin
    resp_t e;
    int    vc;
    if (reset === 1'b0 && sample_valid === 1'b1) begin
      n_samples++;
      check("sample_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        vc = vcyc_q.pop_front();
        check("sample_data", sample_out, e.data);
        check("sample_src", sample_src, e.src);
        check("sample_latency", cyc - vc, 2);
      end
    end
    if (reset === 1'b0 && avg_valid === 1'b1) begin
      n_avg++;
      check("avg_with_sample", sample_valid, 1);
      check("avg_expected", avg_q.size() > 0, 1);
      if (avg_q.size() > 0) check("avg_out", avg_out, avg_q.pop_front());
    end
  end

  initial begin
    int i;
    int t0;
    int s0;
    reset      = 1'b1;
    en         = 1'b0;
    req_demand = 1'b0;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_spi_start", spi_start, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_sample_src", sample_src, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sample_out", sample_out, 12'h000);
    check("rst_avg_out", avg_out, 12'h000);
    step(1);
    reset = 1'b0;
    step(2);

    // Four periodic samples and one average of 250
    spi_lat = 3;
    resp_q.push_back('{data: 12'd100, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'd200, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'd300, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'd400, src: 1'b0, expect_out: 1'b1});
    en = 1'b1;
    wait_samples(4, 200, "t1_four_samples");
    en = 1'b0;
    step(3);
    check("t1_avg_count", n_avg, 1);
    check("t1_avg_value", avg_out, 12'd250);

    // Tick and demand in the same cycle: periodic served first
    resp_q.push_back('{data: 12'h0AB, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'h0CD, src: 1'b1, expect_out: 1'b1});
    s0 = n_samples;
    en = 1'b1;
    step(15);
    req_demand = 1'b1;
    step(1);
    req_demand = 1'b0;
    wait_samples(s0 + 2, 100, "t2_two_samples");
    en = 1'b0;
    step(3);
    check("t2_last_src", sample_src, 1);

    // SPI engine never answers: timeout after 64 WAIT cycles
    s0 = n_samples;
    en = 1'b1;
    wait_start(100, "t3_start_seen");
    step(1);
    en = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) break;
    end
    check("t3_timeout_seen", i < 200, 1);
    check("t3_timeout_delay", cyc - last_start, 65);
    @(negedge clk);
    check("t3_timeout_one_cycle", timeout_err, 0);
    check("t3_no_sample", n_samples, s0);
    check("t3_no_overrun", overrun, 0);
    step(1);
    t0 = n_starts;
    resp_q.push_back('{data: 12'h111, src: 1'b0, expect_out: 1'b1});
    en = 1'b1;
    wait_samples(s0 + 1, 100, "t3_recover_sample");
    en = 1'b0;
    check("t3_new_start", n_starts, t0 + 1);

    // Spurious spi_data_valid while idle
    step(3);
    s0 = n_samples;
    spur_data = 12'hFFF;
    spur = 1'b1;
    step(6);
    @(negedge clk);
    check("t4_spur_no_sample", n_samples, s0);
    check("t4_spur_sample_out", sample_out, 12'h111);
    step(1);

    // Two more periodic samples complete an average of 0xAB,0x111,0x222,0x333
    spi_lat = 1;
    resp_q.push_back('{data: 12'h222, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'h333, src: 1'b0, expect_out: 1'b1});
    en = 1'b1;
    wait_samples(s0 + 2, 100, "t5_two_samples");
    en = 1'b0;
    step(3);
    check("t5_avg_count", n_avg, 2);
    check("t5_avg_value", avg_out, 12'h1C4);

    // Reset during WAIT, then a late spi_data_valid
    spi_lat = 20;
    resp_q.push_back('{data: 12'h555, src: 1'b0, expect_out: 1'b1});
    s0 = n_samples;
    en = 1'b1;
    wait_start(100, "t6_start_seen");
    step(1);
    en = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(30);
    @(negedge clk);
    check("t6_no_sample", n_samples, s0);
    check("t6_sample_out", sample_out, 12'h000);
    check("t6_avg_out", avg_out, 12'h000);
    check("t6_sample_src", sample_src, 0);
    check("t6_overrun", overrun, 0);
    check("t6_spi_start", spi_start, 0);
    step(1);
    spi_lat = 2;
    resp_q.push_back('{data: 12'h0F0, src: 1'b0, expect_out: 1'b1});
    en = 1'b1;
    wait_samples(s0 + 1, 100, "t6_resume_sample");
    en = 1'b0;
    step(3);

    // Slow SPI engine: third tick finds per_pend set -> sticky overrun
    spi_lat = 40;
    resp_q.push_back('{data: 12'h010, src: 1'b0, expect_out: 1'b1});
    resp_q.push_back('{data: 12'h020, src: 1'b0, expect_out: 1'b1});
    s0 = n_samples;
    check("t7_overrun_before", overrun, 0);
    en = 1'b1;
    t0 = cyc;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) break;
    end
    check("t7_overrun_seen", i < 200, 1);
    check("t7_overrun_time", cyc - t0, 48);
    step(1);
    en = 1'b0;
    wait_samples(s0 + 2, 300, "t7_drain_samples");
    step(5);
    check("t7_overrun_sticky", overrun, 1);

    check("end_exp_queue_empty", exp_q.size(), 0);
    check("end_avg_queue_empty", avg_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/adc_spi_scheduler.md
ADC_SPI_SCHEDULER -- requirements
Module: adc_spi_scheduler

Interface
REQ-001 Parameter PERIOD, default 1000, meaning: clk cycles between periodic sample ticks (legal range 8..2^20).
REQ-002 Parameter AVG_LOG2, default 2, meaning: periodic samples per average = 2^AVG_LOG2 (legal range 0..4).
REQ-003 Parameter TIMEOUT, default 64, meaning: maximum cycles in WAIT before the transaction is abandoned.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port en  in  1  enables periodic tick generation.
REQ-007 Port req_demand  in  1  one-cycle on-demand sample request.
REQ-008 Port spi_start  out  1  one-cycle start pulse to the SPI engine.
REQ-009 Port spi_data_valid  in  1  one-cycle pulse from the SPI engine, qualifying spi_data.
REQ-010 Port spi_data  in  12  conversion result.
REQ-011 Port sample_out  out  12  last delivered sample.
REQ-012 Port sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-013 Port sample_src  out  1  source of sample_out: 0 = periodic, 1 = demand.
REQ-014 Port avg_out  out  12  last completed average.
REQ-015 Port avg_valid  out  1  one-cycle pulse when avg_out updates.
REQ-016 Port overrun  out  1  sticky flag: a periodic tick was lost.
REQ-017 Port timeout_err  out  1  one-cycle pulse when a transaction is abandoned.

Function
REQ-018 Tick counter shall count 0..PERIOD-1 while en=1 and shall hold at 0 while en=0.
REQ-019 At count PERIOD-1, per_pend shall be set on the next cycle.
REQ-020 If per_pend is already set when a tick fires, overrun shall set and remain set until reset; the tick shall not be queued.
REQ-021 req_demand shall set dem_pend on the next cycle; a request arriving while dem_pend=1 shall be ignored.
REQ-022 A simultaneous tick and req_demand shall set both pending flags.
REQ-023 The FSM shall have exactly four states: IDLE, START, WAIT, DONE.
REQ-024 IDLE: when per_pend=1, the FSM shall grant periodic (fixed priority); otherwise, when dem_pend=1, it shall grant demand.
REQ-025 In IDLE, on a grant the FSM shall latch the granted source, clear that source's pending flag, and go to START.
REQ-026 START shall drive spi_start=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-027 WAIT: on spi_data_valid=1, the FSM shall latch spi_data and go to DONE.
REQ-028 WAIT: after TIMEOUT cycles without spi_data_valid, the FSM shall pulse timeout_err, go to IDLE, and deliver no sample; the granted request is consumed.
REQ-029 DONE: sample_out and sample_src shall update, with sample_valid=1 for one cycle; the FSM then goes to IDLE.
REQ-030 Latency: spi_data_valid in cycle N shall produce sample_valid in cycle N+2.
REQ-031 spi_data_valid outside WAIT shall be ignored.
REQ-032 Only periodic samples shall accumulate in DONE, into a (12+AVG_LOG2)-bit accumulator, with no overflow possible.
REQ-033 On the 2^AVG_LOG2-th accumulated sample, the block shall set avg_out = (acc + sample) >> AVG_LOG2 (truncating), pulse avg_valid in the same cycle as sample_valid, and clear acc and the sample count.
REQ-034 Demand samples shall never affect the accumulator or the sample count.
REQ-035 en going low mid-transaction shall not abort it; pending flags shall be retained.
REQ-036 Minimum spacing between spi_start pulses shall be 4 cycles.

Reset
REQ-037 While reset=1 at a clk edge, the following shall clear:
- FSM to IDLE;
- tick counter, pending flags, accumulator and sample count to 0;
- spi_start, sample_valid, avg_valid, timeout_err, sample_src and overrun to 0;
- sample_out and avg_out to 12'h000.
REQ-038 Reset asserted mid-transaction shall abandon the transaction with no sample_valid; a spi_data_valid arriving after reset shall be ignored.

Verification
REQ-039 PERIOD=16, AVG_LOG2=2, en=1, SPI model returns 100, 200, 300, 400 -> four sample_valid pulses with sample_src=0; avg_valid once with avg_out=250.
REQ-040 req_demand and tick in the same cycle with data 0x0AB then 0x0CD -> first delivery is periodic 0x0AB; second is demand 0x0CD with sample_src=1; accumulator holds 0x0AB only.
REQ-041 SPI model never returns valid, TIMEOUT=64 -> timeout_err pulses 64 cycles after entering WAIT; no sample_valid; next tick starts a new spi_start.
REQ-042 SPI model latency of 40 cycles, PERIOD=16 -> overrun rises once a second tick fires while per_pend=1, and stays 1.
REQ-043 spi_data_valid at cycle N -> sample_valid exactly at N+2; spurious spi_data_valid in IDLE -> no output change.
REQ-044 reset asserted during WAIT, then spi_data_valid -> all outputs 0, no sample_valid; normal operation resumes on the next tick.
